// File: rtl/otter_io_pkg.sv
// OTTER IOBUS port map, seven-segment control-register layout and a digit-blanking helper.
package otter_io_pkg;

    localparam logic [31:0] SWITCHES_ADDR  = 32'h1100_8000;
    localparam logic [31:0] BUTTONS_ADDR   = 32'h1100_8004;
    localparam logic [31:0] LEDS_ADDR      = 32'h1100_C000;
    localparam logic [31:0] SEGS_ADDR      = 32'h1100_C004;
    localparam logic [31:0] ANODES_ADDR    = 32'h1100_C008;
    localparam logic [31:0] SSEG_DATA_ADDR = 32'h1100_C00C;
    localparam logic [31:0] SSEG_CTRL_ADDR = 32'h1100_C010;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_BLANK_BIT = 1;
    localparam int CTRL_DP_LSB    = 4;

    typedef struct packed {
        logic [3:0] dp_mask;
        logic [1:0] rsvd;
        logic       blank;
        logic       en;
    } sseg_ctrl_t;

    // A digit is blankable when it and every more-significant nibble are zero.
    function automatic logic digit_blank(input logic [15:0] val, input logic [1:0] idx);
        logic res;
        case (idx)
            2'd0:    res = 1'b0;
            2'd1:    res = (val[15:4] == 12'h000);
            2'd2:    res = (val[15:8] == 8'h00);
            2'd3:    res = (val[15:12] == 4'h0);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Hex nibble to active-low {g,f,e,d,c,b,a} glyph decode (Basys3 glyph set).
module hex_to_seg (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Glyph lookup
    always_comb begin
        seg = 7'h7F;
        case (hex)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// IOBUS-mapped four-digit multiplexed seven-segment driver with frame-synchronous
// display update, leading-zero blanking and per-digit decimal points.
module seven_seg_scanner
    import otter_io_pkg::*;
#(
    parameter int REFRESH_DIV = 25000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] iobus_addr,
    input  logic [31:0] iobus_out,
    input  logic        iobus_wr,
    output logic [31:0] rd_data,
    output logic        rd_hit,
    output logic [7:0]  segs,
    output logic [3:0]  an
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(REFRESH_DIV - 1);

    logic [15:0]      shadow_r;
    logic [15:0]      disp_r;
    sseg_ctrl_t       ctrl_r;
    logic [CNT_W-1:0] presc_r;
    logic [1:0]       idx_r;
    logic [3:0]       an_r;
    logic [7:0]       segs_r;

    logic             data_we_s;
    logic             ctrl_we_s;
    logic             tc_s;
    logic [3:0]       nibble_s;
    logic [6:0]       glyph_s;
    logic [3:0]       an_nxt_s;
    logic [7:0]       segs_nxt_s;

    assign data_we_s = iobus_wr && (iobus_addr == SSEG_DATA_ADDR);
    assign ctrl_we_s = iobus_wr && (iobus_addr == SSEG_CTRL_ADDR);
    assign tc_s      = (presc_r == TC_VAL);

    // Register write port; reserved ctrl bits are never stored
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shadow_r <= 16'h0000;
            ctrl_r   <= '0;
        end else begin
            if (data_we_s) begin
                shadow_r <= iobus_out[15:0];
            end
            if (ctrl_we_s) begin
                ctrl_r.en      <= iobus_out[CTRL_EN_BIT];
                ctrl_r.blank   <= iobus_out[CTRL_BLANK_BIT];
                ctrl_r.dp_mask <= iobus_out[CTRL_DP_LSB +: 4];
                ctrl_r.rsvd    <= 2'b00;
            end
        end
    end

    // Free-running scan; display reloads from the pre-edge shadow only at frame wrap
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            presc_r <= '0;
            idx_r   <= 2'd0;
            disp_r  <= 16'h0000;
        end else if (tc_s) begin
            presc_r <= '0;
            idx_r   <= idx_r + 2'd1;
            if (idx_r == 2'd3) begin
                disp_r <= shadow_r;
            end
        end else begin
            presc_r <= presc_r + CNT_W'(1);
        end
    end

    // Active nibble select
    always_comb begin
        nibble_s = 4'h0;
        case (idx_r)
            2'd0:    nibble_s = disp_r[3:0];
            2'd1:    nibble_s = disp_r[7:4];
            2'd2:    nibble_s = disp_r[11:8];
            2'd3:    nibble_s = disp_r[15:12];
            default: nibble_s = 4'h0;
        endcase
    end

    hex_to_seg u_hex_to_seg (
        .hex (nibble_s),
        .seg (glyph_s)
    );

    // Next anode/cathode pattern; dp survives blanking
    always_comb begin
        an_nxt_s   = 4'hF;
        segs_nxt_s = 8'hFF;
        if (ctrl_r.en) begin
            an_nxt_s = ~(4'b0001 << idx_r);
            if (ctrl_r.blank && digit_blank(disp_r, idx_r)) begin
                segs_nxt_s = {~ctrl_r.dp_mask[idx_r], 7'h7F};
            end else begin
                segs_nxt_s = {~ctrl_r.dp_mask[idx_r], glyph_s};
            end
        end else begin
            an_nxt_s   = 4'hF;
            segs_nxt_s = 8'hFF;
        end
    end

    // Output registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            an_r   <= 4'hF;
            segs_r <= 8'hFF;
        end else begin
            an_r   <= an_nxt_s;
            segs_r <= segs_nxt_s;
        end
    end

    assign an   = an_r;
    assign segs = segs_r;

    // Read-back decode
    always_comb begin
        rd_data = 32'h0000_0000;
        rd_hit  = 1'b0;
        if (iobus_addr == SSEG_DATA_ADDR) begin
            rd_data = {16'h0000, shadow_r};
            rd_hit  = 1'b1;
        end else if (iobus_addr == SSEG_CTRL_ADDR) begin
            rd_data = {24'h00_0000, ctrl_r};
            rd_hit  = 1'b1;
        end else begin
            rd_data = 32'h0000_0000;
            rd_hit  = 1'b0;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed, cycle-scheduled bench for seven_seg_scanner with REFRESH_DIV=4.
module tb_seven_seg_scanner;

    localparam logic [31:0] A_DATA = 32'h1100_C00C;
    localparam logic [31:0] A_CTRL = 32'h1100_C010;
    localparam logic [31:0] A_LEDS = 32'h1100_C000;

    localparam int K_CHK = 0;
    localparam int K_WR  = 1;
    localparam int K_RD  = 2;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] iobus_addr = 32'h0;
    logic [31:0] iobus_out = 32'h0;
    logic        iobus_wr = 1'b0;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic [7:0]  segs;
    logic [3:0]  an;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  an;
        logic [7:0]  segs;
        logic        hit;
    } vec_t;

    vec_t vecs[$];

    seven_seg_scanner #(.REFRESH_DIV(4)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .iobus_addr (iobus_addr),
        .iobus_out  (iobus_out),
        .iobus_wr   (iobus_wr),
        .rd_data    (rd_data),
        .rd_hit     (rd_hit),
        .segs       (segs),
        .an         (an)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cmp(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s (vec %0d, cyc %0d): got %h expected %h", nm, idx, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        iobus_wr = 1'b0;
    endtask

    task automatic add_chk(input int c, input logic [3:0] a, input logic [7:0] s);
        vecs.push_back('{c, K_CHK, 32'h0, 32'h0, a, s, 1'b0});
    endtask

    task automatic add_wr(input int c, input logic [31:0] ad, input logic [31:0] d);
        vecs.push_back('{c, K_WR, ad, d, 4'h0, 8'h00, 1'b0});
    endtask

    task automatic add_rd(input int c, input logic [31:0] ad, input logic [31:0] d, input logic h);
        vecs.push_back('{c, K_RD, ad, d, 4'h0, 8'h00, h});
    endtask

    initial begin
        // cyc n = sampled just after the n-th rising edge following reset release
        add_chk(0, 4'hF, 8'hFF);   add_wr(0, A_DATA, 32'h0000_1234);
        add_chk(1, 4'hF, 8'hFF);   add_wr(1, A_CTRL, 32'h0000_0001);
        add_chk(2, 4'hF, 8'hFF);
        add_chk(3, 4'hE, 8'hC0);
        add_chk(17, 4'hE, 8'h99);  add_chk(20, 4'hE, 8'h99);
        add_chk(21, 4'hD, 8'hB0);  add_chk(25, 4'hB, 8'hA4);
        add_chk(29, 4'h7, 8'hF9);  add_chk(32, 4'h7, 8'hF9);
        add_wr(32, A_CTRL, 32'h0000_0003);
        add_wr(33, A_DATA, 32'hFFFF_0005);
        add_chk(49, 4'hE, 8'h92);  add_wr(50, A_DATA, 32'h0000_0000);
        add_chk(53, 4'hD, 8'hFF);  add_chk(57, 4'hB, 8'hFF);
        add_chk(61, 4'h7, 8'hFF);
        add_chk(65, 4'hE, 8'hC0);  add_chk(69, 4'hD, 8'hFF);
        add_wr(79, A_DATA, 32'h0000_ABCD);
        add_chk(81, 4'hE, 8'hC0);  add_chk(84, 4'hE, 8'hC0);
        add_chk(93, 4'h7, 8'hFF);  add_chk(96, 4'h7, 8'hFF);
        add_chk(97, 4'hE, 8'hA1);  add_chk(101, 4'hD, 8'hC6);
        add_chk(105, 4'hB, 8'h83); add_chk(109, 4'h7, 8'h88);
        add_wr(109, A_CTRL, 32'h0000_0021);
        add_chk(113, 4'hE, 8'hA1); add_chk(117, 4'hD, 8'h46);
        add_rd(118, A_DATA, 32'h0000_ABCD, 1'b1);
        add_rd(119, A_CTRL, 32'h0000_0021, 1'b1);
        add_chk(120, 4'hD, 8'h46); add_chk(121, 4'hB, 8'h83);
        add_rd(121, A_LEDS, 32'h0000_0000, 1'b0);
        add_wr(122, A_CTRL, 32'h0000_0020);
        add_chk(123, 4'hB, 8'h83); add_chk(124, 4'hF, 8'hFF);
        add_wr(125, A_LEDS, 32'h0000_FFFF);
        add_rd(127, A_DATA, 32'h0000_ABCD, 1'b1);
        add_rd(127, A_CTRL, 32'h0000_0020, 1'b1);
        add_wr(128, A_CTRL, 32'h0000_0001);
        add_chk(130, 4'hE, 8'hA1); add_chk(133, 4'hD, 8'hC6);

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        cyc = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            while (cyc < vecs[i].cyc) tick();
            case (vecs[i].kind)
                K_CHK: begin
                    cmp("an", i, {28'h0, an}, {28'h0, vecs[i].an});
                    cmp("segs", i, {24'h0, segs}, {24'h0, vecs[i].segs});
                end
                K_WR: begin
                    iobus_addr = vecs[i].addr;
                    iobus_out  = vecs[i].data;
                    iobus_wr   = 1'b1;
                end
                K_RD: begin
                    iobus_addr = vecs[i].addr;
                    #1;
                    cmp("rd_data", i, rd_data, vecs[i].data);
                    cmp("rd_hit", i, {31'h0, rd_hit}, {31'h0, vecs[i].hit});
                end
                default: begin
                    cmp("bad_vec_kind", i, 32'h1, 32'h0);
                end
            endcase
        end

        // Asynchronous reset in the middle of digit 2
        while (cyc < 138) tick();
        cmp("mid_an", 900, {28'h0, an}, 32'h0000_0004 ^ 32'h0000_000F);
        #2;
        RST_N = 1'b0;
        iobus_addr = A_DATA;
        #1;
        cmp("rst_an", 901, {28'h0, an}, 32'h0000_000F);
        cmp("rst_segs", 902, {24'h0, segs}, 32'h0000_00FF);
        cmp("rst_shadow", 903, rd_data, 32'h0000_0000);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        cyc = 0;
        cmp("rel_an", 904, {28'h0, an}, 32'h0000_000F);
        iobus_addr = A_CTRL;
        iobus_out  = 32'h0000_0001;
        iobus_wr   = 1'b1;
        tick();
        cmp("rel1_segs", 905, {24'h0, segs}, 32'h0000_00FF);
        tick();
        cmp("rel2_an", 906, {28'h0, an}, 32'h0000_000E);
        cmp("rel2_segs", 907, {24'h0, segs}, 32'h0000_00C0);
        tick();
        tick();
        cmp("rel4_an", 908, {28'h0, an}, 32'h0000_000E);
        tick();
        cmp("rel5_an", 909, {28'h0, an}, 32'h0000_000D);
        cmp("rel5_segs", 910, {24'h0, segs}, 32'h0000_00C0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
